// File: rtl/fpmu_ctrl.sv
// fpmu_ctrl: two-requester FP16 multiply controller in front of a shared,
// externally instantiated mantissa/exponent multiplier.
//
// Optional build macro: FPMU_CTRL_RNE_EN
//   defined   -> product mantissa is rounded to nearest, ties to even
//   undefined -> discarded product bits are truncated (no rounding logic)
//
// Handshake semantics (both request ports and the response port):
//   A transfer happens on a rising clk_alu edge where valid and ready are both
//   high. reqN_ready is a combinational grant that is only ever high in IDLE,
//   and only for the single requester chosen by the round-robin pointer.
//   rsp_valid is high exactly while the FSM is in RESP. rsp_id, rsp_data and
//   rsp_flags stay stable until the edge where rsp_ready is seen high.
//
// Timeline of one operation (accept edge = edge with reqN_valid & reqN_ready):
//   IDLE (grant) -> MUL (operands on mul_*) -> WAIT (multiplier result valid,
//   captured at the end of the cycle) -> NORM (normalise/round/special-case
//   into the response registers) -> RESP (held until rsp_ready).
module fpmu_ctrl (
  input  logic        clk_alu,
  input  logic        rst_alu_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_flags,
  output logic        busy,
  output logic [10:0] mul_a_mant,
  output logic [10:0] mul_b_mant,
  output logic [4:0]  mul_a_exp,
  output logic [4:0]  mul_b_exp,
  output logic        mul_a_sign,
  output logic        mul_b_sign,
  input  logic [21:0] mul_result_mant,
  input  logic [5:0]  mul_result_exp,
  input  logic        mul_result_sign
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_WAIT = 3'd2,
    S_NORM = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Round-robin pointer: id of the requester granted most recently.
  // Reset value 1 makes req0 the winner of the first simultaneous request.
  logic last_id;

  logic        grant_any;
  logic        grant_id;
  logic [15:0] sel_a;
  logic [15:0] sel_b;

  // Captured multiplier result
  logic [21:0] p_reg;
  logic [5:0]  e_reg;
  logic        s_reg;

  // Normalisation results
  logic signed [6:0] e_norm;
  logic signed [6:0] e_fin;
  logic [9:0]        frac_norm;
  logic [9:0]        frac_fin;

  // Operand classification (taken from the held mul_* operand registers)
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic spec_sign;

  logic [15:0] norm_data;
  logic [2:0]  norm_flags;

  // Round-robin arbitration; only meaningful while idle.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_id;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign sel_a = grant_id ? req1_a : req0_a;
  assign sel_b = grant_id ? req1_b : req0_b;

  // FSM state register.
  always_ff @(posedge clk_alu or negedge rst_alu_n) begin
    if (!rst_alu_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_any) state_nxt = S_MUL;
      S_MUL:   state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_NORM;
      S_NORM:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: grants, response valid and busy indication.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    if (state == S_IDLE) begin
      req0_ready = grant_any && !grant_id;
      req1_ready = grant_any &&  grant_id;
    end else begin
      busy = 1'b1;
    end
    if (state == S_RESP) begin
      rsp_valid = 1'b1;
    end
  end

  // Accept: latch the granted operands straight into the multiplier-facing
  // registers (they stay put until the next accept) and record the id.
  always_ff @(posedge clk_alu or negedge rst_alu_n) begin
    if (!rst_alu_n) begin
      last_id    <= 1'b1;
      rsp_id     <= 1'b0;
      mul_a_sign <= 1'b0;
      mul_b_sign <= 1'b0;
      mul_a_exp  <= 5'd0;
      mul_b_exp  <= 5'd0;
      mul_a_mant <= 11'd0;
      mul_b_mant <= 11'd0;
    end else if (grant_any) begin
      last_id    <= grant_id;
      rsp_id     <= grant_id;
      mul_a_sign <= sel_a[15];
      mul_b_sign <= sel_b[15];
      mul_a_exp  <= sel_a[14:10];
      mul_b_exp  <= sel_b[14:10];
      mul_a_mant <= {(sel_a[14:10] != 5'd0), sel_a[9:0]};
      mul_b_mant <= {(sel_b[14:10] != 5'd0), sel_b[9:0]};
    end
  end

  // Capture the multiplier output at the end of WAIT.
  always_ff @(posedge clk_alu or negedge rst_alu_n) begin
    if (!rst_alu_n) begin
      p_reg <= 22'd0;
      e_reg <= 6'd0;
      s_reg <= 1'b0;
    end else if (state == S_WAIT) begin
      p_reg <= mul_result_mant;
      e_reg <= mul_result_exp;
      s_reg <= mul_result_sign;
    end
  end

  // Normalise the 22-bit product to 1.frac and (optionally) round.
`ifdef FPMU_CTRL_RNE_EN
  logic        rnd_bit;
  logic        sticky;
  logic        rnd_inc;
  logic [10:0] frac_sum;

  always_comb begin
    if (p_reg[21]) begin
      frac_norm = p_reg[20:11];
      rnd_bit   = p_reg[10];
      sticky    = |p_reg[9:0];
      e_norm    = $signed({1'b0, e_reg}) - 7'sd14;
    end else begin
      frac_norm = p_reg[19:10];
      rnd_bit   = p_reg[9];
      sticky    = |p_reg[8:0];
      e_norm    = $signed({1'b0, e_reg}) - 7'sd15;
    end
    rnd_inc  = rnd_bit & (sticky | frac_norm[0]);
    frac_sum = {1'b0, frac_norm} + {10'd0, rnd_inc};
    // A carry out of the fraction means the mantissa became 10.0, i.e. 1.0
    // with the exponent bumped; the bumped exponent feeds the range check.
    frac_fin = frac_sum[9:0];
    e_fin    = frac_sum[10] ? (e_norm + 7'sd1) : e_norm;
  end
`else
  // Bits below the kept fraction are simply dropped.
  logic unused_low_bits;
  assign unused_low_bits = ^p_reg[9:0];

  always_comb begin
    if (p_reg[21]) begin
      frac_norm = p_reg[20:11];
      e_norm    = $signed({1'b0, e_reg}) - 7'sd14;
    end else begin
      frac_norm = p_reg[19:10];
      e_norm    = $signed({1'b0, e_reg}) - 7'sd15;
    end
    frac_fin = frac_norm;
    e_fin    = e_norm;
  end
`endif

  // Special-operand classification; subnormal inputs count as zero.
  always_comb begin
    a_zero    = (mul_a_exp == 5'd0);
    b_zero    = (mul_b_exp == 5'd0);
    a_inf     = (mul_a_exp == 5'h1F) && (mul_a_mant[9:0] == 10'd0);
    b_inf     = (mul_b_exp == 5'h1F) && (mul_b_mant[9:0] == 10'd0);
    a_nan     = (mul_a_exp == 5'h1F) && (mul_a_mant[9:0] != 10'd0);
    b_nan     = (mul_b_exp == 5'h1F) && (mul_b_mant[9:0] != 10'd0);
    spec_sign = mul_a_sign ^ mul_b_sign;
  end

  // Final result selection: invalid > infinity > zero > range-checked normal.
  always_comb begin
    norm_data  = 16'h0000;
    norm_flags = 3'b000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      norm_data  = 16'h7E00;
      norm_flags = 3'b100;
    end else if (a_inf || b_inf) begin
      norm_data = {spec_sign, 5'h1F, 10'h000};
    end else if (a_zero || b_zero) begin
      norm_data = {spec_sign, 15'h0000};
    end else if (e_fin >= 7'sd31) begin
      norm_data  = {s_reg, 5'h1F, 10'h000};
      norm_flags = 3'b001;
    end else if (e_fin <= 7'sd0) begin
      norm_data  = {s_reg, 15'h0000};
      norm_flags = 3'b010;
    end else begin
      norm_data = {s_reg, e_fin[4:0], frac_fin};
    end
  end

  // Response registers: loaded in NORM, held through RESP and beyond.
  always_ff @(posedge clk_alu or negedge rst_alu_n) begin
    if (!rst_alu_n) begin
      rsp_data  <= 16'h0000;
      rsp_flags <= 3'b000;
    end else if (state == S_NORM) begin
      rsp_data  <= norm_data;
      rsp_flags <= norm_flags;
    end
  end

endmodule
